// File: rtl/mips_pkg.sv
// Shared MIPS decode definitions: opcode/funct codes, ALU operation enum, ID/EX register layout.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mips_pkg;

    // Primary opcodes
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_SLTIU = 6'h0B;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // R-type funct codes
    localparam logic [5:0] F_SLL  = 6'h00;
    localparam logic [5:0] F_SRL  = 6'h02;
    localparam logic [5:0] F_SRA  = 6'h03;
    localparam logic [5:0] F_JR   = 6'h08;
    localparam logic [5:0] F_ADD  = 6'h20;
    localparam logic [5:0] F_ADDU = 6'h21;
    localparam logic [5:0] F_SUB  = 6'h22;
    localparam logic [5:0] F_SUBU = 6'h23;
    localparam logic [5:0] F_AND  = 6'h24;
    localparam logic [5:0] F_OR   = 6'h25;
    localparam logic [5:0] F_XOR  = 6'h26;
    localparam logic [5:0] F_NOR  = 6'h27;
    localparam logic [5:0] F_SLT  = 6'h2A;
    localparam logic [5:0] F_SLTU = 6'h2B;

    // ALU_ADD is zero so that a bubble decodes to a harmless add.
    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_NOR  = 4'd5,
        ALU_SLT  = 4'd6,
        ALU_SLTU = 4'd7,
        ALU_SLL  = 4'd8,
        ALU_SRL  = 4'd9,
        ALU_SRA  = 4'd10,
        ALU_LUI  = 4'd11
    } alu_op_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] rs_data;
        logic [31:0] rt_data;
        logic [31:0] imm;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [4:0]  shamt;
        alu_op_t     alu_op;
        logic        alu_src;
        logic        mem_read;
        logic        mem_write;
        logic        reg_write;
        logic        mem_to_reg;
        logic        link;
        logic        illegal;
    } id_ex_t;

    function automatic logic [31:0] sext16(input logic [15:0] v);
        return {{16{v[15]}}, v};
    endfunction

endpackage

// File: rtl/reg_file.sv
// 32x32 register file, two combinational read ports with write-back bypass, one write port.
// Latency: reads combinational, write visible to the array after the clock edge (bypassed same cycle).
// Backpressure: none; a write is always accepted, except during rst where it is discarded.
// Ports: clk, rst (sync, active-high); rs_addr/rt_addr -> rs_data/rt_data; wr_en/wr_addr/wr_data.
module reg_file (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  rs_addr,
    input  logic [4:0]  rt_addr,
    output logic [31:0] rs_data,
    output logic [31:0] rt_data,
    input  logic        wr_en,
    input  logic [4:0]  wr_addr,
    input  logic [31:0] wr_data
);

    logic [31:0] regs [32];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_en && wr_addr != 5'd0) begin
            regs[wr_addr] <= wr_data;
        end
    end

    // $0 is hard-wired; a write landing this cycle on the read address is forwarded.
    always_comb begin
        if (rs_addr == 5'd0) begin
            rs_data = '0;
        end else if (wr_en && wr_addr == rs_addr) begin
            rs_data = wr_data;
        end else begin
            rs_data = regs[rs_addr];
        end

        if (rt_addr == 5'd0) begin
            rt_data = '0;
        end else if (wr_en && wr_addr == rt_addr) begin
            rt_data = wr_data;
        end else begin
            rt_data = regs[rt_addr];
        end
    end

endmodule

// File: rtl/id_stage.sv
// MIPS instruction decode: register file read, control decode, branch/jump resolution, ID/EX register.
// Latency: ID/EX outputs 1 cycle after pc_in/instruction_in; branch_taken/branch_target combinational.
// Backpressure: stall holds ID/EX and suppresses redirect; flush loads a bubble (flush wins over stall).
// Ports: clk, rst; stall, flush; pc_in, instruction_in; wb_reg_write/wb_write_reg/wb_write_data;
//        branch_taken/branch_target (redirect); *_out registered ID/EX fields.
module id_stage
    import mips_pkg::*;
#(
    parameter int RESET_PC_ZERO = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        flush,
    input  logic [31:0] pc_in,
    input  logic [31:0] instruction_in,
    input  logic        wb_reg_write,
    input  logic [4:0]  wb_write_reg,
    input  logic [31:0] wb_write_data,
    output logic        branch_taken,
    output logic [31:0] branch_target,
    output logic [31:0] pc_out,
    output logic [31:0] rs_data_out,
    output logic [31:0] rt_data_out,
    output logic [31:0] imm_out,
    output logic [4:0]  rs_out,
    output logic [4:0]  rt_out,
    output logic [4:0]  rd_out,
    output logic [4:0]  shamt_out,
    output alu_op_t     alu_op_out,
    output logic        alu_src_out,
    output logic        mem_read_out,
    output logic        mem_write_out,
    output logic        reg_write_out,
    output logic        mem_to_reg_out,
    output logic        link_out,
    output logic        illegal_out
);

    localparam logic [31:0] RESET_PC = (RESET_PC_ZERO != 0) ? 32'h0000_0000 : 32'hBFC0_0000;

    logic [5:0]  opcode;
    logic [4:0]  rs, rt, rd, shamt;
    logic [5:0]  funct;
    logic [15:0] imm16;
    logic [31:0] rs_data, rt_data;
    logic [31:0] pc_plus4;
    logic        illegal;
    id_ex_t      dec;
    id_ex_t      id_ex_q;

    assign opcode   = instruction_in[31:26];
    assign rs       = instruction_in[25:21];
    assign rt       = instruction_in[20:16];
    assign rd       = instruction_in[15:11];
    assign shamt    = instruction_in[10:6];
    assign funct    = instruction_in[5:0];
    assign imm16    = instruction_in[15:0];
    assign pc_plus4 = pc_in + 32'd4;

    reg_file u_reg_file (
        .clk     (clk),
        .rst     (rst),
        .rs_addr (rs),
        .rt_addr (rt),
        .rs_data (rs_data),
        .rt_data (rt_data),
        .wr_en   (wb_reg_write),
        .wr_addr (wb_write_reg),
        .wr_data (wb_write_data)
    );

    // Control decode
    always_comb begin
        dec         = '0;
        illegal     = 1'b0;
        dec.pc      = pc_in;
        dec.rs_data = rs_data;
        dec.rt_data = rt_data;
        dec.rs      = rs;
        dec.rt      = rt;
        dec.shamt   = shamt;
        dec.imm     = sext16(imm16);

        case (opcode)
            OP_RTYPE: begin
                dec.reg_write = 1'b1;
                dec.rd        = rd;
                case (funct)
                    F_ADD, F_ADDU: dec.alu_op = ALU_ADD;
                    F_SUB, F_SUBU: dec.alu_op = ALU_SUB;
                    F_AND:         dec.alu_op = ALU_AND;
                    F_OR:          dec.alu_op = ALU_OR;
                    F_XOR:         dec.alu_op = ALU_XOR;
                    F_NOR:         dec.alu_op = ALU_NOR;
                    F_SLT:         dec.alu_op = ALU_SLT;
                    F_SLTU:        dec.alu_op = ALU_SLTU;
                    F_SLL:         dec.alu_op = ALU_SLL;
                    F_SRL:         dec.alu_op = ALU_SRL;
                    F_SRA:         dec.alu_op = ALU_SRA;
                    F_JR: begin
                        dec.reg_write = 1'b0;
                        dec.rd        = 5'd0;
                    end
                    default:       illegal = 1'b1;
                endcase
            end
            OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin
                dec.alu_src   = 1'b1;
                dec.reg_write = 1'b1;
                dec.rd        = rt;
                case (opcode)
                    OP_SLTI:  dec.alu_op = ALU_SLT;
                    OP_SLTIU: dec.alu_op = ALU_SLTU;
                    OP_ANDI: begin
                        dec.alu_op = ALU_AND;
                        dec.imm    = {16'h0, imm16};
                    end
                    OP_ORI: begin
                        dec.alu_op = ALU_OR;
                        dec.imm    = {16'h0, imm16};
                    end
                    OP_XORI: begin
                        dec.alu_op = ALU_XOR;
                        dec.imm    = {16'h0, imm16};
                    end
                    OP_LUI: begin
                        dec.alu_op = ALU_LUI;
                        dec.imm    = {imm16, 16'h0};
                    end
                    default:  dec.alu_op = ALU_ADD;
                endcase
            end
            OP_LW: begin
                dec.alu_src    = 1'b1;
                dec.mem_read   = 1'b1;
                dec.mem_to_reg = 1'b1;
                dec.reg_write  = 1'b1;
                dec.rd         = rt;
            end
            OP_SW: begin
                dec.alu_src   = 1'b1;
                dec.mem_write = 1'b1;
            end
            OP_BEQ, OP_BNE: dec.alu_op = ALU_SUB;
            OP_J:           ;
            OP_JAL: begin
                // EX writes pc_out+8 into $31.
                dec.reg_write = 1'b1;
                dec.link      = 1'b1;
                dec.rd        = 5'd31;
            end
            default: illegal = 1'b1;
        endcase

        // Unknown encodings travel as a bubble flagged illegal so EX can trap.
        if (illegal) begin
            dec.alu_op     = ALU_ADD;
            dec.alu_src    = 1'b0;
            dec.mem_read   = 1'b0;
            dec.mem_write  = 1'b0;
            dec.reg_write  = 1'b0;
            dec.mem_to_reg = 1'b0;
            dec.link       = 1'b0;
            dec.rd         = 5'd0;
            dec.illegal    = 1'b1;
        end
    end

    // Redirect resolution; operands already include the WB bypass.
    always_comb begin
        branch_taken  = 1'b0;
        branch_target = pc_plus4;
        case (opcode)
            OP_BEQ, OP_BNE: begin
                if ((rs_data == rt_data) == (opcode == OP_BEQ)) begin
                    branch_taken  = 1'b1;
                    branch_target = pc_plus4 + (sext16(imm16) << 2);
                end
            end
            OP_J, OP_JAL: begin
                branch_taken  = 1'b1;
                branch_target = {pc_plus4[31:28], instruction_in[25:0], 2'b00};
            end
            OP_RTYPE: begin
                if (funct == F_JR) begin
                    branch_taken  = 1'b1;
                    branch_target = rs_data;
                end
            end
            default: ;
        endcase
        if (stall || rst) begin
            branch_taken = 1'b0;
        end
    end

    // ID/EX register: rst > flush > stall > load
    always_ff @(posedge clk) begin
        if (rst) begin
            id_ex_q    <= '0;
            id_ex_q.pc <= RESET_PC;
        end else if (flush) begin
            id_ex_q <= '0;
        end else if (!stall) begin
            id_ex_q <= dec;
        end
    end

    assign pc_out         = id_ex_q.pc;
    assign rs_data_out    = id_ex_q.rs_data;
    assign rt_data_out    = id_ex_q.rt_data;
    assign imm_out        = id_ex_q.imm;
    assign rs_out         = id_ex_q.rs;
    assign rt_out         = id_ex_q.rt;
    assign rd_out         = id_ex_q.rd;
    assign shamt_out      = id_ex_q.shamt;
    assign alu_op_out     = id_ex_q.alu_op;
    assign alu_src_out    = id_ex_q.alu_src;
    assign mem_read_out   = id_ex_q.mem_read;
    assign mem_write_out  = id_ex_q.mem_write;
    assign reg_write_out  = id_ex_q.reg_write;
    assign mem_to_reg_out = id_ex_q.mem_to_reg;
    assign link_out       = id_ex_q.link;
    assign illegal_out    = id_ex_q.illegal;

endmodule

// File: tb/tb_id_stage.sv
// Self-checking bench for id_stage: directed scenarios plus randomized traffic against a reference model.
// Latency: registered outputs sampled 1 time unit after the clock edge, redirect mid-cycle.
// Backpressure: stall/flush exercised both directed and at random.
module tb_id_stage;
    import mips_pkg::*;

    logic        clk = 1'b0;
    logic        rst, stall, flush;
    logic [31:0] pc_in, instruction_in;
    logic        wb_reg_write;
    logic [4:0]  wb_write_reg;
    logic [31:0] wb_write_data;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic [31:0] pc_out, rs_data_out, rt_data_out, imm_out;
    logic [4:0]  rs_out, rt_out, rd_out, shamt_out;
    alu_op_t     alu_op_out;
    logic        alu_src_out, mem_read_out, mem_write_out, reg_write_out;
    logic        mem_to_reg_out, link_out, illegal_out;

    int errors = 0;
    int checks = 0;

    logic [31:0] mregs [32];
    id_ex_t      obs;
    id_ex_t      exp_q;

    localparam int K_ADD = 0, K_ADDU = 1, K_SUB = 2, K_SUBU = 3, K_AND = 4, K_OR = 5, K_XOR = 6;
    localparam int K_NOR = 7, K_SLT = 8, K_SLTU = 9, K_SLL = 10, K_SRL = 11, K_SRA = 12, K_JR = 13;
    localparam int K_ADDI = 14, K_ADDIU = 15, K_SLTI = 16, K_SLTIU = 17, K_ANDI = 18, K_ORI = 19;
    localparam int K_XORI = 20, K_LUI = 21, K_LW = 22, K_SW = 23, K_BEQ = 24, K_BNE = 25;
    localparam int K_J = 26, K_JAL = 27, K_ILL_OP = 28, K_ILL_FN = 29;

    always #5 clk = ~clk;

    id_stage dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .pc_in(pc_in), .instruction_in(instruction_in),
        .wb_reg_write(wb_reg_write), .wb_write_reg(wb_write_reg), .wb_write_data(wb_write_data),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .pc_out(pc_out), .rs_data_out(rs_data_out), .rt_data_out(rt_data_out), .imm_out(imm_out),
        .rs_out(rs_out), .rt_out(rt_out), .rd_out(rd_out), .shamt_out(shamt_out),
        .alu_op_out(alu_op_out), .alu_src_out(alu_src_out), .mem_read_out(mem_read_out),
        .mem_write_out(mem_write_out), .reg_write_out(reg_write_out),
        .mem_to_reg_out(mem_to_reg_out), .link_out(link_out), .illegal_out(illegal_out)
    );

    always_comb begin
        obs            = '0;
        obs.pc         = pc_out;
        obs.rs_data    = rs_data_out;
        obs.rt_data    = rt_data_out;
        obs.imm        = imm_out;
        obs.rs         = rs_out;
        obs.rt         = rt_out;
        obs.rd         = rd_out;
        obs.shamt      = shamt_out;
        obs.alu_op     = alu_op_out;
        obs.alu_src    = alu_src_out;
        obs.mem_read   = mem_read_out;
        obs.mem_write  = mem_write_out;
        obs.reg_write  = reg_write_out;
        obs.mem_to_reg = mem_to_reg_out;
        obs.link       = link_out;
        obs.illegal    = illegal_out;
    end

    function automatic logic [5:0] code(input int k);
        case (k)
            K_ADD: return 6'h20;   K_ADDU: return 6'h21;  K_SUB: return 6'h22;   K_SUBU: return 6'h23;
            K_AND: return 6'h24;   K_OR: return 6'h25;    K_XOR: return 6'h26;   K_NOR: return 6'h27;
            K_SLT: return 6'h2A;   K_SLTU: return 6'h2B;  K_SLL: return 6'h00;   K_SRL: return 6'h02;
            K_SRA: return 6'h03;   K_JR: return 6'h08;    K_ADDI: return 6'h08;  K_ADDIU: return 6'h09;
            K_SLTI: return 6'h0A;  K_SLTIU: return 6'h0B; K_ANDI: return 6'h0C;  K_ORI: return 6'h0D;
            K_XORI: return 6'h0E;  K_LUI: return 6'h0F;   K_LW: return 6'h23;    K_SW: return 6'h2B;
            K_BEQ: return 6'h04;   K_BNE: return 6'h05;   K_J: return 6'h02;     K_JAL: return 6'h03;
            default: return 6'h3F;
        endcase
    endfunction

    function automatic logic [31:0] enc(input int k, input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [4:0] sh,
                                        input logic [15:0] imm, input logic [25:0] idx);
        logic [5:0] c;
        c = code(k);
        if (k <= K_JR || k == K_ILL_FN) return {6'h00, rs, rt, rd, sh, c};
        if (k == K_J || k == K_JAL) return {c, idx};
        return {c, rs, rt, imm};
    endfunction

    function automatic alu_op_t exp_alu(input int k);
        case (k)
            K_SUB, K_SUBU, K_BEQ, K_BNE: return ALU_SUB;
            K_AND, K_ANDI:               return ALU_AND;
            K_OR, K_ORI:                 return ALU_OR;
            K_XOR, K_XORI:               return ALU_XOR;
            K_NOR:                       return ALU_NOR;
            K_SLT, K_SLTI:               return ALU_SLT;
            K_SLTU, K_SLTIU:             return ALU_SLTU;
            K_SLL:                       return ALU_SLL;
            K_SRL:                       return ALU_SRL;
            K_SRA:                       return ALU_SRA;
            K_LUI:                       return ALU_LUI;
            default:                     return ALU_ADD;
        endcase
    endfunction

    function automatic logic [31:0] read_model(input logic [4:0] a);
        if (a == 5'd0) return 32'h0;
        if (wb_reg_write && wb_write_reg == a) return wb_write_data;
        return mregs[a];
    endfunction

    function automatic id_ex_t predict(input int k, input logic [31:0] pc, input logic [31:0] ins,
                                       input logic [31:0] rsv, input logic [31:0] rtv);
        id_ex_t      e;
        logic [15:0] imm;
        imm       = ins[15:0];
        e         = '0;
        e.pc      = pc;
        e.rs_data = rsv;
        e.rt_data = rtv;
        e.rs      = ins[25:21];
        e.rt      = ins[20:16];
        e.shamt   = ins[10:6];
        if (k == K_ANDI || k == K_ORI || k == K_XORI) e.imm = {16'h0, imm};
        else if (k == K_LUI) e.imm = {imm, 16'h0};
        else e.imm = {{16{imm[15]}}, imm};
        e.alu_op = exp_alu(k);
        if (k <= K_SRA) begin
            e.reg_write = 1'b1; e.rd = ins[15:11];
        end else if (k >= K_ADDI && k <= K_LUI) begin
            e.reg_write = 1'b1; e.alu_src = 1'b1; e.rd = ins[20:16];
        end else if (k == K_LW) begin
            e.reg_write = 1'b1; e.alu_src = 1'b1; e.mem_read = 1'b1; e.mem_to_reg = 1'b1;
            e.rd = ins[20:16];
        end else if (k == K_SW) begin
            e.alu_src = 1'b1; e.mem_write = 1'b1;
        end else if (k == K_JAL) begin
            e.reg_write = 1'b1; e.link = 1'b1; e.rd = 5'd31;
        end else if (k >= K_ILL_OP) begin
            e.illegal = 1'b1;
        end
        return e;
    endfunction

    function automatic logic [32:0] exp_redirect(input int k, input logic [31:0] pc, input logic [31:0] ins,
                                                 input logic [31:0] rsv, input logic [31:0] rtv);
        logic [31:0] pc4, off;
        pc4 = pc + 32'd4;
        off = {{14{ins[15]}}, ins[15:0], 2'b00};
        if (k == K_BEQ && rsv == rtv) return {1'b1, pc4 + off};
        if (k == K_BNE && rsv != rtv) return {1'b1, pc4 + off};
        if (k == K_J || k == K_JAL) return {1'b1, pc4[31:28], ins[25:0], 2'b00};
        if (k == K_JR) return {1'b1, rsv};
        return {1'b0, pc4};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_wb(input logic we, input logic [4:0] r, input logic [31:0] d);
        wb_reg_write  = we;
        wb_write_reg  = r;
        wb_write_data = d;
    endtask

    task automatic test_reset();
        rst = 1'b1; stall = 1'b0; flush = 1'b0;
        pc_in = 32'h1000_0000;
        instruction_in = enc(K_JAL, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h40);
        set_wb(1'b1, 5'd7, 32'hDEAD_BEEF);
        for (int c = 0; c < 2; c++) begin
            #2;
            checks++;
            if (branch_taken !== 1'b0) begin
                $display("FAIL reset_taken[%0d]: got %b expected 0", c, branch_taken);
                errors++;
            end
            tick();
        end
        rst = 1'b0;
        set_wb(1'b0, 5'd0, 32'h0);
        checks++;
        if (obs !== '0) begin
            $display("FAIL reset_idex: got %h expected 0", obs);
            errors++;
        end
        for (int i = 0; i < 32; i++) begin
            instruction_in = enc(K_ADD, 5'(i), 5'(31 - i), 5'd1, 5'd0, 16'h0, 26'h0);
            tick();
            checks++;
            if (rs_data_out !== 32'h0 || rt_data_out !== 32'h0) begin
                $display("FAIL reset_reg[%0d]: got rs=%h rt=%h expected 0", i, rs_data_out, rt_data_out);
                errors++;
            end
        end
    endtask

    task automatic test_bypass();
        pc_in = 32'h40;
        instruction_in = enc(K_ADD, 5'd5, 5'd0, 5'd3, 5'd0, 16'h0, 26'h0);
        set_wb(1'b1, 5'd5, 32'h1234);
        tick();
        set_wb(1'b0, 5'd0, 32'h0);
        checks++;
        if (rs_data_out !== 32'h1234 || rd_out !== 5'd3 || reg_write_out !== 1'b1 || rt_data_out !== 32'h0) begin
            $display("FAIL bypass_add: got rs=%h rd=%0d rw=%b rt=%h expected 1234 3 1 0",
                     rs_data_out, rd_out, reg_write_out, rt_data_out);
            errors++;
        end
        instruction_in = enc(K_ADD, 5'd5, 5'd5, 5'd6, 5'd0, 16'h0, 26'h0);
        tick();
        checks++;
        if (rs_data_out !== 32'h1234 || rt_data_out !== 32'h1234) begin
            $display("FAIL bypass_stored: got rs=%h rt=%h expected 1234", rs_data_out, rt_data_out);
            errors++;
        end
    endtask

    task automatic test_r0();
        instruction_in = enc(K_ADD, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0);
        set_wb(1'b1, 5'd0, 32'hFFFF_FFFF);
        tick();
        set_wb(1'b0, 5'd0, 32'h0);
        checks++;
        if (rs_data_out !== 32'h0 || rt_data_out !== 32'h0) begin
            $display("FAIL r0_bypass: got rs=%h rt=%h expected 0", rs_data_out, rt_data_out);
            errors++;
        end
        tick();
        checks++;
        if (rs_data_out !== 32'h0 || reg_write_out !== 1'b1 || rd_out !== 5'd0) begin
            $display("FAIL r0_read: got rs=%h rw=%b rd=%0d expected 0 1 0", rs_data_out, reg_write_out, rd_out);
            errors++;
        end
    endtask

    task automatic test_branch();
        pc_in = 32'h100;
        instruction_in = 32'h0;
        set_wb(1'b1, 5'd1, 32'hAA);
        tick();
        instruction_in = enc(K_BEQ, 5'd1, 5'd2, 5'd0, 5'd0, 16'hFFFF, 26'h0);
        set_wb(1'b1, 5'd2, 32'hAA);
        #2;
        checks++;
        if (branch_taken !== 1'b1 || branch_target !== 32'h100) begin
            $display("FAIL beq_equal: got %b %h expected 1 00000100", branch_taken, branch_target);
            errors++;
        end
        tick();
        checks++;
        if (rd_out !== 5'd0 || reg_write_out !== 1'b0 || alu_op_out !== ALU_SUB) begin
            $display("FAIL beq_ctrl: got rd=%0d rw=%b alu=%0d expected 0 0 %0d", rd_out, reg_write_out,
                     alu_op_out, ALU_SUB);
            errors++;
        end
        set_wb(1'b1, 5'd2, 32'h55);
        #2;
        checks++;
        if (branch_taken !== 1'b0 || branch_target !== 32'h104) begin
            $display("FAIL beq_unequal: got %b %h expected 0 00000104", branch_taken, branch_target);
            errors++;
        end
        tick();
        set_wb(1'b0, 5'd0, 32'h0);
        instruction_in = enc(K_BNE, 5'd1, 5'd2, 5'd0, 5'd0, 16'hFFFF, 26'h0);
        #2;
        checks++;
        if (branch_taken !== 1'b1 || branch_target !== 32'h100) begin
            $display("FAIL bne_taken: got %b %h expected 1 00000100", branch_taken, branch_target);
            errors++;
        end
        instruction_in = enc(K_BEQ, 5'd1, 5'd1, 5'd0, 5'd0, 16'hFFFF, 26'h0);
        stall = 1'b1;
        #2;
        checks++;
        if (branch_taken !== 1'b0) begin
            $display("FAIL beq_stalled: got %b expected 0", branch_taken);
            errors++;
        end
        stall = 1'b0;
        #1;
        checks++;
        if (branch_taken !== 1'b1) begin
            $display("FAIL beq_unstalled: got %b expected 1", branch_taken);
            errors++;
        end
        tick();
    endtask

    task automatic test_jal();
        pc_in = 32'h1000_0000;
        instruction_in = enc(K_JAL, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h40);
        #2;
        checks++;
        if (branch_taken !== 1'b1 || branch_target !== 32'h1000_0100) begin
            $display("FAIL jal_target: got %b %h expected 1 10000100", branch_taken, branch_target);
            errors++;
        end
        tick();
        checks++;
        if (rd_out !== 5'd31 || link_out !== 1'b1 || reg_write_out !== 1'b1 || pc_out !== 32'h1000_0000) begin
            $display("FAIL jal_ctrl: got rd=%0d link=%b rw=%b pc=%h expected 31 1 1 10000000",
                     rd_out, link_out, reg_write_out, pc_out);
            errors++;
        end
        instruction_in = enc(K_JR, 5'd9, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0);
        set_wb(1'b1, 5'd9, 32'h0040_0080);
        #2;
        checks++;
        if (branch_taken !== 1'b1 || branch_target !== 32'h0040_0080) begin
            $display("FAIL jr_target: got %b %h expected 1 00400080", branch_taken, branch_target);
            errors++;
        end
        tick();
        set_wb(1'b0, 5'd0, 32'h0);
    endtask

    task automatic test_stall_flush();
        pc_in = 32'h200;
        instruction_in = enc(K_ADDI, 5'd0, 5'd4, 5'd0, 5'd0, 16'hFFFF, 26'h0);
        tick();
        checks++;
        if (imm_out !== 32'hFFFF_FFFF || rd_out !== 5'd4 || alu_src_out !== 1'b1) begin
            $display("FAIL addi_load: got imm=%h rd=%0d src=%b expected ffffffff 4 1", imm_out, rd_out, alu_src_out);
            errors++;
        end
        stall = 1'b1;
        pc_in = 32'h204;
        instruction_in = enc(K_J, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h123);
        for (int c = 0; c < 2; c++) begin
            #2;
            checks++;
            if (branch_taken !== 1'b0) begin
                $display("FAIL stall_redirect[%0d]: got %b expected 0", c, branch_taken);
                errors++;
            end
            tick();
            checks++;
            if (imm_out !== 32'hFFFF_FFFF || rd_out !== 5'd4 || pc_out !== 32'h200 || reg_write_out !== 1'b1) begin
                $display("FAIL stall_hold[%0d]: got imm=%h rd=%0d pc=%h rw=%b expected ffffffff 4 200 1",
                         c, imm_out, rd_out, pc_out, reg_write_out);
                errors++;
            end
        end
        flush = 1'b1;
        tick();
        checks++;
        if (obs !== '0) begin
            $display("FAIL stall_flush: got %h expected 0", obs);
            errors++;
        end
        stall = 1'b0; flush = 1'b0;
        instruction_in = {6'h3F, 26'h3FF_FFFF};
        tick();
        checks++;
        if (illegal_out !== 1'b1 || reg_write_out !== 1'b0 || rd_out !== 5'd0 || mem_read_out !== 1'b0) begin
            $display("FAIL illegal_op: got ill=%b rw=%b rd=%0d mr=%b expected 1 0 0 0",
                     illegal_out, reg_write_out, rd_out, mem_read_out);
            errors++;
        end
        flush = 1'b1;
        tick();
        flush = 1'b0;
        checks++;
        if (obs !== '0) begin
            $display("FAIL flush_illegal: got %h expected 0", obs);
            errors++;
        end
    endtask

    task automatic test_random();
        rst = 1'b1; stall = 1'b0; flush = 1'b0;
        set_wb(1'b0, 5'd0, 32'h0);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 32; i++) mregs[i] = 32'h0;
        exp_q = '0;
        for (int n = 0; n < 600; n++) begin
            int          k;
            logic [4:0]  rs, rt;
            logic [31:0] ins, rsv, rtv;
            logic [32:0] red;
            id_ex_t      nxt;
            logic        exp_tk;
            k  = int'($urandom_range(0, 29));
            rs = 5'($urandom_range(0, 7));
            rt = ((k == K_BEQ || k == K_BNE) && $urandom_range(0, 1) == 1) ? rs : 5'($urandom_range(0, 7));
            ins = enc(k, rs, rt, 5'($urandom), 5'($urandom),
                      ($urandom_range(0, 3) == 0) ? 16'($urandom_range(16'hFFF0, 16'hFFFF)) : 16'($urandom),
                      26'($urandom));
            pc_in          = $urandom & 32'hFFFF_FFFC;
            instruction_in = ins;
            rst            = ($urandom_range(0, 63) == 0);
            flush          = ($urandom_range(0, 15) == 0);
            stall          = ($urandom_range(0, 5) == 0);
            set_wb(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
                   ($urandom_range(0, 2) == 0) ? 32'($urandom_range(0, 3)) : $urandom);
            rsv    = read_model(ins[25:21]);
            rtv    = read_model(ins[20:16]);
            red    = exp_redirect(k, pc_in, ins, rsv, rtv);
            nxt    = predict(k, pc_in, ins, rsv, rtv);
            exp_tk = red[32] && !stall && !rst;
            #2;
            checks++;
            if (branch_taken !== exp_tk) begin
                $display("FAIL random_taken[%0d]: got %b expected %b", n, branch_taken, exp_tk);
                errors++;
            end
            if (!stall && !rst) begin
                checks++;
                if (branch_target !== red[31:0]) begin
                    $display("FAIL random_target[%0d]: got %h expected %h", n, branch_target, red[31:0]);
                    errors++;
                end
            end
            tick();
            if (rst) begin
                exp_q = '0;
                for (int i = 0; i < 32; i++) mregs[i] = 32'h0;
            end else begin
                if (flush) exp_q = '0;
                else if (!stall) exp_q = nxt;
                if (wb_reg_write && wb_write_reg != 5'd0) mregs[wb_write_reg] = wb_write_data;
            end
            checks++;
            if (obs !== exp_q) begin
                $display("FAIL random_idex[%0d]: got %h expected %h", n, obs, exp_q);
                errors++;
            end
        end
        rst = 1'b0; stall = 1'b0; flush = 1'b0;
    endtask

    initial begin
        test_reset();
        test_bypass();
        test_r0();
        test_branch();
        test_jal();
        test_stall_flush();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
